// File: rtl/last_fetched_store_table_pkg.sv
// Shared widths, reserved store-set IDs and payload types for the LFST.
package last_fetched_store_table_pkg;

  localparam int unsigned LFST_WIDTH = 11;
  localparam int unsigned TAG_WIDTH  = 6;
  localparam int unsigned LFST_DEPTH = 1 << LFST_WIDTH;

  typedef logic [LFST_WIDTH-1:0] ssid_t;
  typedef logic [TAG_WIDTH-1:0]  tag_t;

  // SSID 0 means "no dependency"; SSID 1 chains all device accesses.
  localparam ssid_t LFST_ID_NONE   = ssid_t'(0);
  localparam ssid_t LFST_ID_DEVICE = ssid_t'(1);

  // One table entry / one dependency result.
  typedef struct packed {
    logic valid;
    tag_t tag;
  } dep_t;

  function automatic logic ssid_live(input ssid_t s);
    return s != LFST_ID_NONE;
  endfunction

endpackage

// File: rtl/last_fetched_store_table_if.sv
// Dispatch/issue/dependency bundle between the LSU front end and the LFST.
//   master : drives dispatch slots, issue clear, stall, flush; receives deps
//   slave  : the LFST itself
interface last_fetched_store_table_if;
  import last_fetched_store_table_pkg::*;

  logic  stall;
  logic  flush;
  logic  instr0_valid;
  logic  instr0_is_store;
  ssid_t instr0_ssid;
  tag_t  instr0_tag;
  logic  instr1_valid;
  logic  instr1_is_store;
  ssid_t instr1_ssid;
  tag_t  instr1_tag;
  logic  issue_valid;
  ssid_t issue_ssid;
  tag_t  issue_tag;
  logic  instr0_dep_valid;
  tag_t  instr0_dep_tag;
  logic  instr1_dep_valid;
  tag_t  instr1_dep_tag;

  modport master (
    output stall, flush,
    output instr0_valid, instr0_is_store, instr0_ssid, instr0_tag,
    output instr1_valid, instr1_is_store, instr1_ssid, instr1_tag,
    output issue_valid, issue_ssid, issue_tag,
    input  instr0_dep_valid, instr0_dep_tag, instr1_dep_valid, instr1_dep_tag
  );

  modport slave (
    input  stall, flush,
    input  instr0_valid, instr0_is_store, instr0_ssid, instr0_tag,
    input  instr1_valid, instr1_is_store, instr1_ssid, instr1_tag,
    input  issue_valid, issue_ssid, issue_tag,
    output instr0_dep_valid, instr0_dep_tag, instr1_dep_valid, instr1_dep_tag
  );

endinterface

// File: rtl/last_fetched_store_table_lfst_entry_array.sv
// LFST valid/tag storage: two combinational read ports, two dispatch write
// ports (port 1 wins on collision), one tag-matched clear port, and flush.
//   clk, rst_n        : clock, async active-low reset (valid bits only)
//   flush_i           : clear every valid bit, drop all writes/clears
//   rd*_idx_i/_c_o    : read address / combinational entry (SSID 0 reads invalid)
//   wr*_en/idx/tag_i  : dispatch writes (SSID 0 ignored)
//   clr_en/idx/tag_i  : issue clear, only if the entry still holds clr_tag_i
module last_fetched_store_table_lfst_entry_array
  import last_fetched_store_table_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  flush_i,
  input  ssid_t rd0_idx_i,
  output dep_t  rd0_c_o,
  input  ssid_t rd1_idx_i,
  output dep_t  rd1_c_o,
  input  logic  wr0_en_i,
  input  ssid_t wr0_idx_i,
  input  tag_t  wr0_tag_i,
  input  logic  wr1_en_i,
  input  ssid_t wr1_idx_i,
  input  tag_t  wr1_tag_i,
  input  logic  clr_en_i,
  input  ssid_t clr_idx_i,
  input  tag_t  clr_tag_i
);

  logic [LFST_DEPTH-1:0] valid_q, valid_d;
  tag_t                  tag_q [LFST_DEPTH];

  logic wr0_live, wr1_live, clr_hit;

  assign wr0_live = wr0_en_i && ssid_live(wr0_idx_i);
  assign wr1_live = wr1_en_i && ssid_live(wr1_idx_i);
  // A tag mismatch means a younger store now owns the entry.
  assign clr_hit  = clr_en_i && ssid_live(clr_idx_i) && valid_q[clr_idx_i]
                    && (tag_q[clr_idx_i] == clr_tag_i);

  assign rd0_c_o = {valid_q[rd0_idx_i] && ssid_live(rd0_idx_i), tag_q[rd0_idx_i]};
  assign rd1_c_o = {valid_q[rd1_idx_i] && ssid_live(rd1_idx_i), tag_q[rd1_idx_i]};

  // Clear is applied first so a same-cycle dispatch write overrides it.
  always_comb begin
    valid_d = valid_q;
    if (flush_i) begin
      valid_d = '0;
    end else begin
      if (clr_hit)  valid_d[clr_idx_i] = 1'b0;
      if (wr0_live) valid_d[wr0_idx_i] = 1'b1;
      if (wr1_live) valid_d[wr1_idx_i] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) valid_q <= '0;
    else        valid_q <= valid_d;
  end

  // Tags are not reset; they are only observed through a set valid bit.
  always_ff @(posedge clk) begin
    if (!flush_i) begin
      if (wr0_live) tag_q[wr0_idx_i] <= wr0_tag_i;
      if (wr1_live) tag_q[wr1_idx_i] <= wr1_tag_i;
    end
  end

endmodule

// File: rtl/last_fetched_store_table.sv
// Last Fetched Store Table: returns, per dispatch slot, the ROB tag of the
// youngest un-issued store in the slot's store set, one cycle later.
//   clk, rst_n : clock, async active-low reset
//   lfst       : slave side of the dispatch/issue/dependency bundle
module last_fetched_store_table
  import last_fetched_store_table_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst_n,
  last_fetched_store_table_if.slave    lfst
);

  dep_t rd0, rd1;
  dep_t dep0_d, dep0_q, dep1_d, dep1_q;
  logic run, fwd1;

  assign run = !lfst.stall && !lfst.flush;

  last_fetched_store_table_lfst_entry_array u_array (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush_i   (lfst.flush),
    .rd0_idx_i (lfst.instr0_ssid),
    .rd0_c_o   (rd0),
    .rd1_idx_i (lfst.instr1_ssid),
    .rd1_c_o   (rd1),
    .wr0_en_i  (run && lfst.instr0_valid && lfst.instr0_is_store),
    .wr0_idx_i (lfst.instr0_ssid),
    .wr0_tag_i (lfst.instr0_tag),
    .wr1_en_i  (run && lfst.instr1_valid && lfst.instr1_is_store),
    .wr1_idx_i (lfst.instr1_ssid),
    .wr1_tag_i (lfst.instr1_tag),
    .clr_en_i  (lfst.issue_valid),
    .clr_idx_i (lfst.issue_ssid),
    .clr_tag_i (lfst.issue_tag)
  );

  // Slot 1 depends on a store in slot 0 of the same bundle before it is in the array.
  assign fwd1 = lfst.instr0_valid && lfst.instr0_is_store && lfst.instr1_valid
                && ssid_live(lfst.instr1_ssid) && (lfst.instr0_ssid == lfst.instr1_ssid);

  // Flush zeroes the outputs, stall holds them.
  always_comb begin
    dep0_d = dep0_q;
    dep1_d = dep1_q;
    if (lfst.flush) begin
      dep0_d = '0;
      dep1_d = '0;
    end else if (!lfst.stall) begin
      dep0_d = (lfst.instr0_valid && rd0.valid) ? rd0 : '0;
      if (fwd1)                                  dep1_d = {1'b1, lfst.instr0_tag};
      else if (lfst.instr1_valid && rd1.valid)   dep1_d = rd1;
      else                                       dep1_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dep0_q <= '0;
      dep1_q <= '0;
    end else begin
      dep0_q <= dep0_d;
      dep1_q <= dep1_d;
    end
  end

  assign lfst.instr0_dep_valid = dep0_q.valid;
  assign lfst.instr0_dep_tag   = dep0_q.tag;
  assign lfst.instr1_dep_valid = dep1_q.valid;
  assign lfst.instr1_dep_tag   = dep1_q.tag;

endmodule
